alu32: RTL and testbench
========================

Name: alu32

Overview:
- 32-bit registered ALU: two operands, 4-bit opcode, one result, four status flags.
- Sits in the execute stage of the datapath.
- Combinational compute; result and flags are captured on the rising clock edge when Enable is high.
- Result and flags hold when Enable is low.

Parameters:
- WIDTH, 32, operand/result width; the opcode map and flag rules below assume 32.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- in1  input  32  operand A
- in2  input  32  operand B (shift/rotate amount = in2[4:0])
- opcode  input  4  operation select
- Enable  input  1  capture enable
- alu_out  output  32  registered result
- parity_flag  output  1  registered XOR-reduction of result (1 = odd number of ones)
- zero_flag  output  1  registered, result == 0
- sign_flag  output  1  registered, result[31]
- carry_flag  output  1  registered carry/borrow/overflow per opcode

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst_n=0, asynchronous): alu_out=0, all flags=0, held while rst_n low.
- Release takes effect at the next rising clk.
- Latency: one cycle. Inputs sampled at rising clk with Enable=1 appear on outputs after that edge.
- Enable=0: all outputs hold their previous values. Input changes are ignored.
- Opcode map (R = result, C = carry_flag; C=0 unless stated):
  - 0 ADD: R = in1+in2. C = bit 32 of the 33-bit sum.
  - 1 SUB: R = in1-in2. C = borrow (in1 < in2 unsigned).
  - 2 MUL: R = low 32 bits of the unsigned 64-bit product. C = 1 if upper 32 bits are nonzero.
  - 3 AND; 4 OR; 5 XOR; 6 NAND; 7 NOR; 8 XNOR (all bitwise).
  - 9 NOT: R = ~in1.
  - 10 SHL: R = in1 << n. C = in1[32-n] when n>0, else 0.
  - 11 SHR logical: R = in1 >> n. C = in1[n-1] when n>0, else 0.
  - 12 SRA arithmetic: as SHR but sign-filled. C = in1[n-1] when n>0, else 0.
  - 13 ROL: R = in1 rotated left by n. C = R[0] when n>0, else 0.
  - 14 ROR: R = in1 rotated right by n. C = R[31] when n>0, else 0.
  - 15 SLTU: R = 32'd1 if in1 < in2 unsigned, else 0.
- Shift/rotate amount: n = in2[4:0]. in2[31:5] ignored. n=0 gives R=in1, C=0.
- Flags derive from the same-cycle R: zero = (R==0), sign = R[31], parity = ^R.
- All arithmetic is unsigned modulo 2^32 except SRA sign fill.
- No X propagation: every opcode is defined, and the default branch is unreachable.
- Opcode glitches between edges have no effect; only the value at the capturing edge matters.

Decomposition:
- Package alu_pkg: opcode localparams/enum (ALU_ADD … ALU_SLTU), WIDTH constant.
- One sub-module alu_shifter: SHL/SHR/SRA/ROL/ROR, returning result plus shifted-out carry.
- Top holds the opcode mux, flag logic and output registers.

Test Plan:
- Reset/enable: rst_n=0 mid-run with Enable=1 → outputs 0 immediately, no clock needed. Enable=0 with changing inputs → outputs hold.
- ADD overflow: in1=in2=0xFFFFFFFF, op 0 → alu_out=0xFFFFFFFE, carry=1, sign=1, parity=1, zero=0, one cycle after the edge.
- Small operands: in1=in2=0x000000FF, ops 0..15 →
  - ADD 0x1FE (parity 0)
  - SUB 0, zero=1, carry=0
  - MUL 0xFE01
  - AND 0xFF; OR 0xFF; XOR 0 (zero=1)
  - NAND 0xFFFFFF00; NOR 0xFFFFFF00; XNOR 0xFFFFFFFF
  - NOT 0xFFFFFF00
  - SHL (n=31) 0x80000000, carry=1; SHR 0, carry=0; SRA 0
  - ROL (n=31) 0x8000007F; ROR (n=31) 0x1FE
  - SLTU 0
- Borrow: in1=1, in2=2, SUB → 0xFFFFFFFF, carry=1, sign=1. SLTU → 1.
- MUL overflow: in1=0x10000, in2=0x10000 → alu_out=0, zero=1, carry=1.
- Rapid opcode changes (5,6,3,5,6,7) within one clock period → only the opcode at the capturing edge (7, NOR) is reflected. Shift with in2=32 (n=0) → alu_out=in1, carry=0.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode map and width shared by the alu32 datapath
package alu_pkg;

   localparam int WIDTH = 32;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_MUL  = 4'd2,
      ALU_AND  = 4'd3,
      ALU_OR   = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_NAND = 4'd6,
      ALU_NOR  = 4'd7,
      ALU_XNOR = 4'd8,
      ALU_NOT  = 4'd9,
      ALU_SHL  = 4'd10,
      ALU_SHR  = 4'd11,
      ALU_SRA  = 4'd12,
      ALU_ROL  = 4'd13,
      ALU_ROR  = 4'd14,
      ALU_SLTU = 4'd15
   } alu_op_e;

endpackage

// File: rtl/alu_shifter.sv
// rtl/alu_shifter.sv - shift/rotate unit returning result and shifted-out carry
module alu_shifter
   import alu_pkg::*;
(
   input  logic [WIDTH-1:0] a,
   input  logic [4:0]       n,
   input  logic [3:0]       opcode,
   output logic [WIDTH-1:0] result,
   output logic             carry
);

   // One guard bit beside the operand catches the last bit shifted out.
   logic [WIDTH:0]        shl_ext;
   logic [WIDTH:0]        shr_ext;
   logic signed [WIDTH:0] sra_ext;
   logic [WIDTH-1:0]      rol_r;
   logic [WIDTH-1:0]      ror_r;
   logic [5:0]            n_inv;

   assign n_inv   = 6'd32 - {1'b0, n};
   assign shl_ext = {1'b0, a} << n;
   assign shr_ext = {a, 1'b0} >> n;
   assign sra_ext = $signed({a, 1'b0}) >>> n;
   assign rol_r   = (a << n) | (a >> n_inv);
   assign ror_r   = (a >> n) | (a << n_inv);

   always_comb begin
      result = a;
      carry  = 1'b0;
      case (opcode)
         ALU_SHL: begin
            result = shl_ext[WIDTH-1:0];
            carry  = shl_ext[WIDTH];
         end
         ALU_SHR: begin
            result = shr_ext[WIDTH:1];
            carry  = shr_ext[0];
         end
         ALU_SRA: begin
            result = sra_ext[WIDTH:1];
            carry  = sra_ext[0];
         end
         ALU_ROL: begin
            result = rol_r;
            carry  = (n != 5'd0) & rol_r[0];
         end
         ALU_ROR: begin
            result = ror_r;
            carry  = (n != 5'd0) & ror_r[WIDTH-1];
         end
         default: begin
            result = a;
            carry  = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/alu32.sv
// rtl/alu32.sv - registered 32-bit execute-stage ALU with parity/zero/sign/carry flags
module alu32 #(
   parameter int WIDTH = alu_pkg::WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic [3:0]       opcode,
   input  logic             Enable,
   output logic [WIDTH-1:0] alu_out,
   output logic             parity_flag,
   output logic             zero_flag,
   output logic             sign_flag,
   output logic             carry_flag
);
   import alu_pkg::*;

   logic [WIDTH:0]       sum;
   logic [WIDTH:0]       diff;
   logic [2*WIDTH-1:0]   prod;
   logic [WIDTH-1:0]     sh_result;
   logic                 sh_carry;
   logic [WIDTH-1:0]     result;
   logic                 carry;

   assign sum  = {1'b0, in1} + {1'b0, in2};
   assign diff = {1'b0, in1} - {1'b0, in2};
   assign prod = {{WIDTH{1'b0}}, in1} * {{WIDTH{1'b0}}, in2};

   alu_shifter u_shifter (
      .a      (in1),
      .n      (in2[4:0]),
      .opcode (opcode),
      .result (sh_result),
      .carry  (sh_carry)
   );

   always_comb begin
      result = '0;
      carry  = 1'b0;
      case (opcode)
         ALU_ADD:  begin result = sum[WIDTH-1:0];  carry = sum[WIDTH];  end
         // The wrapped difference's top bit is the unsigned borrow.
         ALU_SUB:  begin result = diff[WIDTH-1:0]; carry = diff[WIDTH]; end
         ALU_MUL:  begin result = prod[WIDTH-1:0]; carry = |prod[2*WIDTH-1:WIDTH]; end
         ALU_AND:  result = in1 & in2;
         ALU_OR:   result = in1 | in2;
         ALU_XOR:  result = in1 ^ in2;
         ALU_NAND: result = ~(in1 & in2);
         ALU_NOR:  result = ~(in1 | in2);
         ALU_XNOR: result = ~(in1 ^ in2);
         ALU_NOT:  result = ~in1;
         ALU_SHL, ALU_SHR, ALU_SRA, ALU_ROL, ALU_ROR: begin
            result = sh_result;
            carry  = sh_carry;
         end
         ALU_SLTU: result = {{(WIDTH-1){1'b0}}, (in1 < in2)};
         default:  begin result = '0; carry = 1'b0; end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_out     <= '0;
         parity_flag <= 1'b0;
         zero_flag   <= 1'b0;
         sign_flag   <= 1'b0;
         carry_flag  <= 1'b0;
      end else if (Enable) begin
         alu_out     <= result;
         parity_flag <= ^result;
         zero_flag   <= (result == '0);
         sign_flag   <= result[WIDTH-1];
         carry_flag  <= carry;
      end
   end

endmodule

// File: tb/tb_alu32.sv
// tb/tb_alu32.sv - directed and randomized bench for alu32
module tb_alu32;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] in1;
   logic [31:0] in2;
   logic [3:0]  opcode;
   logic        enable;
   logic [31:0] alu_out;
   logic        parity_flag;
   logic        zero_flag;
   logic        sign_flag;
   logic        carry_flag;

   int          checks = 0;
   int          passes = 0;
   logic [35:0] exp_state;

   always #5 clk = ~clk;

   alu32 dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in1         (in1),
      .in2         (in2),
      .opcode      (opcode),
      .Enable      (enable),
      .alu_out     (alu_out),
      .parity_flag (parity_flag),
      .zero_flag   (zero_flag),
      .sign_flag   (sign_flag),
      .carry_flag  (carry_flag)
   );

   // {result, parity, zero, sign, carry}
   function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] op);
      logic [31:0]     r;
      logic            c;
      int              n;
      longint unsigned w;
      n = int'(b[4:0]);
      c = 1'b0;
      r = a;
      case (op)
         4'd0:  begin w = a; w = w + b; r = w[31:0]; c = (w > 64'hFFFF_FFFF); end
         4'd1:  begin r = a - b; c = (a < b); end
         4'd2:  begin w = a; w = w * b; r = w[31:0]; c = ((w >> 32) != 0); end
         4'd3:  r = a & b;
         4'd4:  r = a | b;
         4'd5:  r = a ^ b;
         4'd6:  r = ~(a & b);
         4'd7:  r = ~(a | b);
         4'd8:  r = ~(a ^ b);
         4'd9:  r = ~a;
         4'd10: begin r = a << n; c = (n > 0) ? a[32-n] : 1'b0; end
         4'd11: begin r = a >> n; c = (n > 0) ? a[n-1] : 1'b0; end
         4'd12: begin r = $unsigned($signed(a) >>> n); c = (n > 0) ? a[n-1] : 1'b0; end
         4'd13: begin repeat (n) r = {r[30:0], r[31]}; c = (n > 0) ? r[0] : 1'b0; end
         4'd14: begin repeat (n) r = {r[0], r[31:1]}; c = (n > 0) ? r[31] : 1'b0; end
         default: r = (a < b) ? 32'd1 : 32'd0;
      endcase
      return {r, ($countones(r) % 2) == 1, r == 32'd0, r[31], c};
   endfunction

   task automatic check(input string tag, input logic [35:0] exp);
      logic [35:0] obs;
      obs = {alu_out, parity_flag, zero_flag, sign_flag, carry_flag};
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic step(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] op, input logic en);
      in1 = a; in2 = b; opcode = op; enable = en;
      @(posedge clk); #1;
      if (en) exp_state = model(a, b, op);
      check(tag, exp_state);
   endtask

   logic [31:0] small_r [16];

   initial begin
      small_r = '{32'h1FE, 32'h0, 32'hFE01, 32'hFF, 32'hFF, 32'h0, 32'hFFFFFF00,
                  32'hFFFFFF00, 32'hFFFFFFFF, 32'hFFFFFF00, 32'h80000000, 32'h0,
                  32'h0, 32'h8000007F, 32'h1FE, 32'h0};
      rst_n = 1'b0; enable = 1'b1; in1 = 32'h1234; in2 = 32'h5; opcode = 4'd0;
      exp_state = '0;
      #1 check("reset_async", 36'h0);
      @(posedge clk); #1 check("reset_held", 36'h0);
      rst_n = 1'b1;

      step("add_ovf", 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd0, 1'b1);
      check("add_ovf_const", {32'hFFFFFFFE, 1'b1, 1'b0, 1'b1, 1'b1});

      for (int op = 0; op < 16; op++) begin
         step($sformatf("small_op%0d", op), 32'hFF, 32'hFF, 4'(op), 1'b1);
         checks++;
         assert (alu_out === small_r[op]) passes++;
         else $error("FAIL small_const_op%0d: observed %h expected %h", op, alu_out, small_r[op]);
      end

      step("sub_borrow", 32'd1, 32'd2, 4'd1, 1'b1);
      check("sub_borrow_const", {32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 1'b1});
      step("sltu_true", 32'd1, 32'd2, 4'd15, 1'b1);
      check("sltu_const", {32'd1, 1'b1, 1'b0, 1'b0, 1'b0});
      step("mul_ovf", 32'h10000, 32'h10000, 4'd2, 1'b1);
      check("mul_ovf_const", {32'h0, 1'b0, 1'b1, 1'b0, 1'b1});
      step("shl_n0", 32'hA5A5_0F0F, 32'd32, 4'd10, 1'b1);
      check("shl_n0_const", {32'hA5A5_0F0F, 1'b0, 1'b0, 1'b1, 1'b0});

      // Enable low: outputs must not follow changing inputs.
      for (int i = 0; i < 3; i++)
         step("enable_hold", $urandom, $urandom, 4'($urandom_range(0, 15)), 1'b0);

      // Opcode glitches between edges; only the last value is captured.
      in1 = 32'h0F0F_1234; in2 = 32'h00F0_4321; enable = 1'b1;
      opcode = 4'd5; #1 opcode = 4'd6; #1 opcode = 4'd3;
      #1 opcode = 4'd5; #1 opcode = 4'd6; #1 opcode = 4'd7;
      @(posedge clk); #1;
      exp_state = model(in1, in2, 4'd7);
      check("glitch_nor", exp_state);

      // Mid-cycle reset with Enable high clears outputs without a clock edge.
      #2 rst_n = 1'b0;
      #1 exp_state = '0;
      check("reset_midrun", exp_state);
      @(posedge clk); #1 check("reset_midrun_held", exp_state);
      rst_n = 1'b1;
      step("post_reset", 32'h8000_0001, 32'h7FFF_FFFF, 4'd0, 1'b1);

      for (int i = 0; i < 300; i++)
         step("random", $urandom, $urandom, 4'($urandom_range(0, 15)),
              ($urandom_range(0, 3) != 0));

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
